// File: rtl/mc_control_fsm_if.sv
// Control bus between the multi-cycle controller and the shared datapath:
// opcode/memory-ready in, every datapath enable and mux select out.
interface mc_control_fsm_if;
    logic [6:0] opcode;
    logic       mem_ready;

    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] PCSource;
    logic [1:0] MemtoReg;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic       instr_done;
    logic       illegal;
    logic [3:0] state;

    // Controller side
    modport master (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite,
               PCSource, MemtoReg, ALUSrcA, ALUSrcB, ALUOp,
               instr_done, illegal, state
    );

    // Datapath side
    modport slave (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite,
               PCSource, MemtoReg, ALUSrcA, ALUSrcB, ALUOp,
               instr_done, illegal, state
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle RISC-V control unit: decodes the IR opcode and sequences the
// shared datapath one state per clock, with optional memory handshake and trap.
module mc_control_fsm #(
    parameter bit MEM_HANDSHAKE = 1'b0,
    parameter bit TRAP_ILLEGAL  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    mc_control_fsm_if.master bus
);
    localparam int unsigned SW = 4;

    localparam logic [SW-1:0] S_IF    = 4'd0;
    localparam logic [SW-1:0] S_ID    = 4'd1;
    localparam logic [SW-1:0] S_MA    = 4'd2;
    localparam logic [SW-1:0] S_MEM_R = 4'd3;
    localparam logic [SW-1:0] S_MRCS  = 4'd4;
    localparam logic [SW-1:0] S_MEM_W = 4'd5;
    localparam logic [SW-1:0] S_EX    = 4'd6;
    localparam logic [SW-1:0] S_RT    = 4'd7;
    localparam logic [SW-1:0] S_BC    = 4'd8;
    localparam logic [SW-1:0] S_EXI   = 4'd9;
    localparam logic [SW-1:0] S_LUI   = 4'd10;
    localparam logic [SW-1:0] S_JR    = 4'd11;
    localparam logic [SW-1:0] S_JMP   = 4'd12;
    localparam logic [SW-1:0] S_TRAP  = 4'd15;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic [SW-1:0] r_state;
    logic [SW-1:0] w_next;
    logic          w_mem_done;
    logic          w_legal;

    // Single-cycle memory always completes; otherwise wait for the handshake
    assign w_mem_done = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;

    always_comb begin
        w_legal = 1'b0;
        case (bus.opcode)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: w_legal = 1'b1;
            default:                           w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IF;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = S_IF;
        case (r_state)
            S_IF:    w_next = w_mem_done ? S_ID : S_IF;
            S_ID: begin
                case (bus.opcode)
                    OP_R:               w_next = S_EX;
                    OP_I:               w_next = S_EXI;
                    OP_LOAD, OP_STORE:  w_next = S_MA;
                    OP_BRANCH:          w_next = S_BC;
                    OP_LUI:             w_next = S_LUI;
                    OP_AUIPC:           w_next = S_RT;
                    OP_JAL:             w_next = S_JMP;
                    OP_JALR:            w_next = S_JR;
                    default:            w_next = TRAP_ILLEGAL ? S_TRAP : S_IF;
                endcase
            end
            S_MA: begin
                if (bus.opcode == OP_LOAD) begin
                    w_next = S_MEM_R;
                end else if (bus.opcode == OP_STORE) begin
                    w_next = S_MEM_W;
                end else begin
                    w_next = S_IF;
                end
            end
            S_MEM_R: w_next = w_mem_done ? S_MRCS : S_MEM_R;
            S_MRCS:  w_next = S_IF;
            S_MEM_W: w_next = w_mem_done ? S_IF : S_MEM_W;
            S_EX:    w_next = S_RT;
            S_EXI:   w_next = S_RT;
            S_LUI:   w_next = S_RT;
            S_RT:    w_next = S_IF;
            S_BC:    w_next = S_IF;
            S_JR:    w_next = S_JMP;
            S_JMP:   w_next = S_IF;
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_IF;
        endcase
    end

    // Moore decode of the datapath controls; reset forces everything low
    always_comb begin
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.PCSource    = 2'b00;
        bus.MemtoReg    = 2'b00;
        bus.ALUSrcA     = 2'b00;
        bus.ALUSrcB     = 2'b00;
        bus.ALUOp       = 2'b00;
        bus.instr_done  = 1'b0;
        bus.illegal     = 1'b0;
        bus.state       = 4'd0;
        if (!reset) begin
            bus.state = r_state;
            case (r_state)
                S_IF: begin
                    bus.MemRead = 1'b1;
                    bus.ALUSrcB = 2'b01;
                    bus.IRWrite = w_mem_done;
                    bus.PCWrite = w_mem_done;
                end
                S_ID: begin
                    bus.ALUSrcA    = 2'b10;
                    bus.ALUSrcB    = 2'b10;
                    bus.instr_done = !TRAP_ILLEGAL && !w_legal;
                end
                S_MA: begin
                    bus.ALUSrcA = 2'b01;
                    bus.ALUSrcB = 2'b10;
                end
                S_MEM_R: begin
                    bus.IorD    = 1'b1;
                    bus.MemRead = 1'b1;
                end
                S_MRCS: begin
                    bus.RegWrite   = 1'b1;
                    bus.MemtoReg   = 2'b01;
                    bus.instr_done = 1'b1;
                end
                S_MEM_W: begin
                    bus.IorD       = 1'b1;
                    bus.MemWrite   = 1'b1;
                    bus.instr_done = w_mem_done;
                end
                S_EX: begin
                    bus.ALUSrcA = 2'b01;
                    bus.ALUOp   = 2'b10;
                end
                S_EXI: begin
                    bus.ALUSrcA = 2'b01;
                    bus.ALUSrcB = 2'b10;
                    bus.ALUOp   = 2'b11;
                end
                S_LUI: begin
                    bus.ALUSrcA = 2'b11;
                    bus.ALUSrcB = 2'b10;
                end
                S_RT: begin
                    bus.RegWrite   = 1'b1;
                    bus.instr_done = 1'b1;
                end
                S_BC: begin
                    bus.ALUSrcA     = 2'b01;
                    bus.ALUOp       = 2'b01;
                    bus.PCWriteCond = 1'b1;
                    bus.PCSource    = 2'b01;
                    bus.instr_done  = 1'b1;
                end
                S_JR: begin
                    bus.ALUSrcA = 2'b01;
                    bus.ALUSrcB = 2'b10;
                end
                S_JMP: begin
                    bus.PCWrite    = 1'b1;
                    bus.PCSource   = 2'b01;
                    bus.RegWrite   = 1'b1;
                    bus.MemtoReg   = 2'b10;
                    bus.instr_done = 1'b1;
                end
                S_TRAP:  bus.illegal = 1'b1;
                default: bus.illegal = 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: instance A has handshake+trap, instance B has
// neither; expected per-cycle controls come from an instruction-level model.
module tb_mc_control_fsm;
    typedef struct packed {
        logic       pcw, pcwc, iord, mrd, mwr, irw, rgw;
        logic [1:0] pcs, m2r, asa, asb, aop;
        logic       done, ill;
        logic [3:0] st;
    } ctl_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    mc_control_fsm_if bus_a ();
    mc_control_fsm_if bus_b ();

    mc_control_fsm #(.MEM_HANDSHAKE(1'b1), .TRAP_ILLEGAL(1'b1)) dut_a (
        .clk(clk), .reset(rst_a), .bus(bus_a));
    mc_control_fsm #(.MEM_HANDSHAKE(1'b0), .TRAP_ILLEGAL(1'b0)) dut_b (
        .clk(clk), .reset(rst_b), .bus(bus_b));

    ctl_t act_a, act_b;
    assign act_a = {bus_a.PCWrite, bus_a.PCWriteCond, bus_a.IorD, bus_a.MemRead,
                    bus_a.MemWrite, bus_a.IRWrite, bus_a.RegWrite, bus_a.PCSource,
                    bus_a.MemtoReg, bus_a.ALUSrcA, bus_a.ALUSrcB, bus_a.ALUOp,
                    bus_a.instr_done, bus_a.illegal, bus_a.state};
    assign act_b = {bus_b.PCWrite, bus_b.PCWriteCond, bus_b.IorD, bus_b.MemRead,
                    bus_b.MemWrite, bus_b.IRWrite, bus_b.RegWrite, bus_b.PCSource,
                    bus_b.MemtoReg, bus_b.ALUSrcA, bus_b.ALUSrcB, bus_b.ALUOp,
                    bus_b.instr_done, bus_b.illegal, bus_b.state};

    int n_pass  = 0;
    int n_total = 0;

    // Expected cycle list: state number, mem_ready to drive, and the one
    // condition-dependent bit (ready for IF/MEM_W, done for ID)
    int q_st[$];
    bit q_drv[$];
    bit q_flag[$];

    function automatic bit is_legal(logic [6:0] op);
        return op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
                          OP_LUI, OP_AUIPC, OP_JAL, OP_JALR};
    endfunction

    // Control table per state, as listed for the controller
    function automatic ctl_t model(int st, bit flag);
        ctl_t c;
        c = '0;
        c.st = 4'(st);
        case (st)
            0:  begin c.mrd = 1; c.asb = 2'b01; c.irw = flag; c.pcw = flag; end
            1:  begin c.asa = 2'b10; c.asb = 2'b10; c.done = flag; end
            2:  begin c.asa = 2'b01; c.asb = 2'b10; end
            3:  begin c.iord = 1; c.mrd = 1; end
            4:  begin c.rgw = 1; c.m2r = 2'b01; c.done = 1; end
            5:  begin c.iord = 1; c.mwr = 1; c.done = flag; end
            6:  begin c.asa = 2'b01; c.aop = 2'b10; end
            7:  begin c.rgw = 1; c.done = 1; end
            8:  begin c.asa = 2'b01; c.aop = 2'b01; c.pcwc = 1; c.pcs = 2'b01; c.done = 1; end
            9:  begin c.asa = 2'b01; c.asb = 2'b10; c.aop = 2'b11; end
            10: begin c.asa = 2'b11; c.asb = 2'b10; end
            11: begin c.asa = 2'b01; c.asb = 2'b10; end
            12: begin c.pcw = 1; c.pcs = 2'b01; c.rgw = 1; c.m2r = 2'b10; c.done = 1; end
            15: c.ill = 1;
            default: c = '0;
        endcase
        return c;
    endfunction

    task automatic push(int st, bit drv, bit flag);
        q_st.push_back(st);
        q_drv.push_back(drv);
        q_flag.push_back(flag);
    endtask

    // A memory-timed state: waits then completion, or one cycle ignoring ready
    task automatic push_mem(int st, bit hs, int waits);
        if (hs) begin
            for (int i = 0; i < waits; i++) push(st, 1'b0, 1'b0);
            push(st, 1'b1, 1'b1);
        end else begin
            push(st, 1'($urandom), 1'b1);
        end
    endtask

    // Instruction-level sequence: IF, ID, then the opcode's execution phases
    task automatic build(bit sel, logic [6:0] op, int w_if, int w_mem, int trap_cycles);
        bit hs;
        hs = !sel;
        q_st.delete(); q_drv.delete(); q_flag.delete();
        push_mem(0, hs, w_if);
        push(1, 1'($urandom), !is_legal(op) && sel);
        case (op)
            OP_R:      begin push(6, 1'($urandom), 0); push(7, 1'($urandom), 0); end
            OP_I:      begin push(9, 1'($urandom), 0); push(7, 1'($urandom), 0); end
            OP_LOAD:   begin push(2, 1'($urandom), 0); push_mem(3, hs, w_mem); push(4, 1'($urandom), 0); end
            OP_STORE:  begin push(2, 1'($urandom), 0); push_mem(5, hs, w_mem); end
            OP_BRANCH: push(8, 1'($urandom), 0);
            OP_LUI:    begin push(10, 1'($urandom), 0); push(7, 1'($urandom), 0); end
            OP_AUIPC:  push(7, 1'($urandom), 0);
            OP_JAL:    push(12, 1'($urandom), 0);
            OP_JALR:   begin push(11, 1'($urandom), 0); push(12, 1'($urandom), 0); end
            default:   if (!sel) for (int i = 0; i < trap_cycles; i++) push(15, 1'($urandom), 0);
        endcase
    endtask

    task automatic drive(bit sel, logic rst, logic [6:0] op, logic rdy);
        if (!sel) begin
            rst_a = rst; rst_b = 1'b1;
            bus_a.opcode = op; bus_a.mem_ready = rdy;
        end else begin
            rst_b = rst; rst_a = 1'b1;
            bus_b.opcode = op; bus_b.mem_ready = rdy;
        end
    endtask

    task automatic do_reset(bit sel, int cycles, string tag);
        ctl_t act;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            drive(sel, 1'b1, 7'($urandom), 1'($urandom));
            #1;
            act = sel ? act_b : act_a;
            n_total++;
            if (act !== '0) $display("FAIL %s reset cycle %0d: got %h expected 0", tag, i, act);
            else n_pass++;
        end
    endtask

    // Play the queued cycles against one instance; stop early if asked
    task automatic run_seq(bit sel, logic [6:0] op, string tag, int stop);
        ctl_t act, exp;
        int n;
        n = (stop >= 0 && stop < q_st.size()) ? stop : q_st.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive(sel, 1'b0, (q_st[i] == 0) ? 7'($urandom) : op, q_drv[i]);
            #1;
            exp = model(q_st[i], q_flag[i]);
            act = sel ? act_b : act_a;
            n_total++;
            if (act !== exp)
                $display("FAIL %s step %0d op=%b: got %h expected %h", tag, i, op, act, exp);
            else n_pass++;
        end
    endtask

    task automatic run_instr(bit sel, logic [6:0] op, int w_if, int w_mem, int trap_cycles, string tag);
        build(sel, op, w_if, w_mem, trap_cycles);
        run_seq(sel, op, tag, -1);
        if (!sel && !is_legal(op)) do_reset(sel, 1, {tag, "_trap_exit"});
    endtask

    task automatic test_reset;
        do_reset(0, 3, "reset_a");
        run_instr(0, OP_R, 0, 0, 0, "post_reset_a");
        do_reset(1, 3, "reset_b");
        run_instr(1, OP_R, 0, 0, 0, "post_reset_b");
    endtask

    task automatic test_rtype;
        run_instr(1, OP_R, 0, 0, 0, "rtype_b");
        run_instr(1, OP_I, 0, 0, 0, "itype_b");
        run_instr(1, OP_LUI, 0, 0, 0, "lui_b");
        run_instr(1, OP_AUIPC, 0, 0, 0, "auipc_b");
    endtask

    task automatic test_load_store;
        do_reset(0, 1, "ls_rst");
        run_instr(0, OP_LOAD, 0, 2, 0, "load_stall_a");
        run_instr(0, OP_STORE, 0, 3, 0, "store_stall_a");
        run_instr(0, OP_STORE, 0, 0, 0, "store_a");
        run_instr(1, OP_LOAD, 0, 0, 0, "load_b");
        run_instr(1, OP_STORE, 0, 0, 0, "store_b");
    endtask

    task automatic test_jumps;
        do_reset(0, 1, "jmp_rst");
        run_instr(0, OP_JAL, 1, 0, 0, "jal_a");
        run_instr(0, OP_JALR, 0, 0, 0, "jalr_a");
        run_instr(0, OP_BRANCH, 0, 0, 0, "branch_a");
        run_instr(1, OP_JAL, 0, 0, 0, "jal_b");
        run_instr(1, OP_JALR, 0, 0, 0, "jalr_b");
    endtask

    task automatic test_illegal;
        do_reset(0, 1, "ill_rst");
        run_instr(0, 7'b1111111, 0, 0, 20, "trap_a");
        run_instr(0, OP_I, 0, 0, 0, "after_trap_a");
        run_instr(1, 7'b1111111, 0, 0, 0, "skip_b");
        run_instr(1, OP_LUI, 0, 0, 0, "after_skip_b");
    endtask

    task automatic test_if_stall;
        do_reset(0, 1, "ifs_rst");
        run_instr(0, OP_BRANCH, 4, 0, 0, "if_stall_a");
        run_instr(0, OP_R, 2, 0, 0, "if_stall2_a");
    endtask

    task automatic test_reset_abort;
        do_reset(0, 1, "abort_rst");
        build(0, OP_LOAD, 0, 5, 0);
        run_seq(0, OP_LOAD, "abort_load_a", 5);
        do_reset(0, 2, "abort_a");
        run_instr(0, OP_AUIPC, 0, 0, 0, "after_abort_a");
    endtask

    task automatic test_back_to_back;
        logic [6:0] ops [13];
        ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC,
                OP_JAL, OP_JALR, 7'h7F, 7'h00, 7'h0F, 7'h73};
        for (int s = 0; s < 2; s++) begin
            do_reset(1'(s), 1, "b2b_rst");
            for (int k = 0; k < 30; k++) begin
                logic [6:0] op;
                op = ops[$urandom_range(0, 12)];
                run_instr(1'(s), op, $urandom_range(0, 3), $urandom_range(0, 3), 3, "b2b");
            end
        end
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        bus_a.opcode = '0; bus_a.mem_ready = 1'b0;
        bus_b.opcode = '0; bus_b.mem_ready = 1'b0;
        test_reset;
        test_rtype;
        test_load_store;
        test_jumps;
        test_illegal;
        test_if_stall;
        test_reset_abort;
        test_back_to_back;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Parameterised multi-cycle control unit for the RISC-V core, the next generation of the multi-cycle controller. It decodes the 7-bit opcode held in the instruction register and sequences the shared datapath one state per clock. On top of the base R/load/store/branch flow it adds I-type ALU, LUI, AUIPC, JAL and JALR, and an optional memory-ready handshake for variable-latency memory. It also adds illegal-opcode trapping and an instruction-retire pulse. It sits between the instruction register and every datapath mux and enable.

## Interface
- MEM_HANDSHAKE, 0, 1 makes IF/MEM_R/MEM_W wait for mem_ready; 0 ignores mem_ready (single-cycle memory).
- TRAP_ILLEGAL, 1, 1 makes an unknown opcode enter sticky TRAP; 0 silently returns to IF.
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- opcode  in  7  instr[6:0] from the instruction register.
- mem_ready  in  1  memory has completed the current access this cycle.
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite  out  1 each  standard enables (PCWriteCond = write PC if branch taken).
- PCSource  out  2  00 ALU result, 01 ALUOut, 10/11 reserved (drive 00).
- MemtoReg  out  2  00 ALUOut, 01 MDR, 10 PC (link value PC+4).
- ALUSrcA  out  2  00 PC, 01 rs1, 10 OldPC, 11 zero.
- ALUSrcB  out  2  00 rs2, 01 const 4, 10 imm.
- ALUOp  out  2  00 add, 01 branch compare, 10 R-funct decode, 11 I-funct decode.
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction.
- illegal  out  1  high while in TRAP.
- state  out  4  current state encoding, for debug.

## Operation
- States and encodings: IF=0, ID=1, MA=2, MEM_R=3, MRCS=4, MEM_W=5, EX=6, RT=7, BC=8, EXI=9, LUI=10, JR=11, JMP=12, TRAP=15. Codes 13 and 14 are unused and go to IF.
- Outputs are decoded combinationally from the state. Any signal not listed for a state is 0.
- IF: MemRead=1, ALUSrcA=00, ALUSrcB=01, IorD=0. IRWrite and PCWrite follow the memory handshake (see Timing).
- ID: ALUSrcA=10, ALUSrcB=10, ALUOp=00, so ALUOut = OldPC + imm. The datapath selects the immediate format from the opcode.
- Transitions out of ID, by opcode:
  - 0110011 → EX
  - 0010011 → EXI
  - 0000011 and 0100011 → MA
  - 1100011 → BC
  - 0110111 → LUI
  - 0010111 (AUIPC) → RT
  - 1101111 (JAL) → JMP
  - 1100111 (JALR) → JR
  - any other opcode → TRAP when TRAP_ILLEGAL=1, otherwise IF.
- MA: ALUSrcA=01, ALUSrcB=10, ALUOp=00. Goes to MEM_R on a load, MEM_W on a store, otherwise IF.
- MEM_R: IorD=1, MemRead=1, then MRCS. MRCS: RegWrite=1, MemtoReg=01, then IF.
- MEM_W: IorD=1, MemWrite=1, then IF.
- EX: ALUSrcA=01, ALUSrcB=00, ALUOp=10, then RT.
- EXI: ALUSrcA=01, ALUSrcB=10, ALUOp=11, then RT.
- LUI: ALUSrcA=11, ALUSrcB=10, ALUOp=00, then RT.
- RT: RegWrite=1, MemtoReg=00, then IF.
- BC: ALUSrcA=01, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, then IF.
- JR: ALUSrcA=01, ALUSrcB=10, ALUOp=00, then JMP. The datapath clears ALU bit 0.
- JMP: PCWrite=1, PCSource=01, RegWrite=1, MemtoReg=10, then IF. The link register captures the pre-edge PC, which is already PC+4.
- TRAP: all enables 0 and illegal=1. The FSM stays in TRAP until reset.
- instr_done is 1 in the terminal cycle of each instruction: MRCS, MEM_W (on completion), RT, BC, JMP, and ID when the opcode is illegal and TRAP_ILLEGAL=0.

## Timing
- Reset: while reset=1 all outputs are forced to 0 (state output reads 0). The first edge after reset deasserts enters or stays in IF.
- Reset mid-instruction aborts it. No partial write enables are asserted in the reset cycle.
- Latency with zero wait states, in cycles:
  - BC, JMP-JAL, AUIPC: 3
  - R-type, I-ALU, LUI, store, JALR: 4
  - load: 5
- With MEM_HANDSHAKE=1, IF, MEM_R and MEM_W hold their state and keep MemRead/MemWrite/IorD asserted until mem_ready=1.
  - In IF, IRWrite and PCWrite are asserted only in the cycle mem_ready=1.
  - MEM_W: instr_done is asserted only in the cycle mem_ready=1.
  - Leave the state on the edge where mem_ready=1.
- With MEM_HANDSHAKE=0, mem_ready is ignored and each of these states lasts exactly 1 cycle.
- mem_ready is ignored in every other state.
- opcode must be stable from ID through the end of the instruction. The IR is written only in IF.

## Test plan
- Reset: hold reset=1 for 3 cycles, release → all outputs 0 during reset; next cycle state=0, MemRead=1, ALUSrcB=01.
- R-type 0110011, MEM_HANDSHAKE=0 → state sequence 0,1,6,7; RegWrite=1 in state 7; instr_done pulses once; next state 0.
- Load 0000011, MEM_HANDSHAKE=1, mem_ready low for 2 cycles in MEM_R → sequence 0,1,2,3,3,3,4; MemRead=IorD=1 throughout state 3; RegWrite=1 with MemtoReg=01 in state 4.
- JAL 1101111 → 0,1,12; in state 12 PCWrite=1, PCSource=01, RegWrite=1, MemtoReg=10. JALR 1100111 → 0,1,11,12.
- Illegal opcode 1111111, TRAP_ILLEGAL=1 → state 15 with illegal=1 held for 20 cycles with all enables 0; reset recovers to IF. With TRAP_ILLEGAL=0 → back to 0 after ID with instr_done=1.
- IF stall: mem_ready=0 for 4 cycles in IF → IRWrite=PCWrite=0 until the mem_ready=1 cycle, then both 1 for exactly one cycle.
